// File: rtl/pe_cube_seq.sv
// Job sequencer for a PE cube: per tile it clears the accumulators, streams Len
// data/weight reads, waits for the pipeline to drain, and then moves to the next tile.
module pe_cube_seq #(
    parameter int ARRAY_NUM    = 3,
    parameter int ADDR_W       = 10,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iStart,
    input  logic                   iAbort,
    input  logic                   iStall,
    input  logic [CNT_W-1:0]       iCfgLen,
    input  logic [CNT_W-1:0]       iCfgTiles,
    input  logic [ADDR_W-1:0]      iCfgDataBase,
    input  logic [ADDR_W-1:0]      iCfgWeightBase,
    input  logic [3*ARRAY_NUM-1:0] iCfgPattern,
    input  logic [ARRAY_NUM-2:0]   iCfgPassLeft,
    input  logic [4:0]             iCfgShift,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oErr,
    output logic                   oDataRdEn,
    output logic                   oWeightRdEn,
    output logic [ADDR_W-1:0]      oDataAddr,
    output logic [ADDR_W-1:0]      oWeightAddr,
    output logic                   oClearAcc,
    output logic [3*ARRAY_NUM-1:0] oCfsInputPattern,
    output logic [ARRAY_NUM-2:0]   oCfsPassDataLeft,
    output logic [4:0]             oCfsOutputLeftShift,
    output logic [CNT_W-1:0]       oTileIdx,
    output logic [2:0]             oDbgState
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The step counter doubles as the drain timer, since the two never overlap.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       tiles_q, tiles_d;
    logic [ADDR_W-1:0]      wbase_q, wbase_d;
    logic [3*ARRAY_NUM-1:0] pattern_q, pattern_d;
    logic [ARRAY_NUM-2:0]   pass_q, pass_d;
    logic [4:0]             shift_q, shift_d;
    logic [CNT_W-1:0]       tile_q, tile_d;
    logic [CNT_W-1:0]       step_q, step_d;
    logic [ADDR_W-1:0]      dptr_q, dptr_d;
    logic [ADDR_W-1:0]      wptr_q, wptr_d;

    logic pat_ok;
    logic cfg_ok;

    always_comb begin
        pat_ok = 1'b1;
        for (int i = 0; i < ARRAY_NUM; i++) begin
            if (iCfgPattern[3*i +: 3] > 3'd4) begin
                pat_ok = 1'b0;
            end
        end
    end

    assign cfg_ok = pat_ok && (iCfgLen != '0) && (iCfgTiles != '0);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            len_q     <= '0;
            tiles_q   <= '0;
            wbase_q   <= '0;
            pattern_q <= '0;
            pass_q    <= '0;
            shift_q   <= '0;
            tile_q    <= '0;
            step_q    <= '0;
            dptr_q    <= '0;
            wptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            len_q     <= len_d;
            tiles_q   <= tiles_d;
            wbase_q   <= wbase_d;
            pattern_q <= pattern_d;
            pass_q    <= pass_d;
            shift_q   <= shift_d;
            tile_q    <= tile_d;
            step_q    <= step_d;
            dptr_q    <= dptr_d;
            wptr_q    <= wptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        len_d     = len_q;
        tiles_d   = tiles_q;
        wbase_d   = wbase_q;
        pattern_d = pattern_q;
        pass_d    = pass_q;
        shift_d   = shift_q;
        tile_d    = tile_q;
        step_d    = step_q;
        dptr_d    = dptr_q;
        wptr_d    = wptr_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (cfg_ok) begin
                        len_d     = iCfgLen;
                        tiles_d   = iCfgTiles;
                        wbase_d   = iCfgWeightBase;
                        pattern_d = iCfgPattern;
                        pass_d    = iCfgPassLeft;
                        shift_d   = iCfgShift;
                        tile_d    = '0;
                        dptr_d    = iCfgDataBase;
                        state_d   = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                step_d  = '0;
                wptr_d  = wbase_q;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (!iStall) begin
                    dptr_d = dptr_q + 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    step_d = step_q + 1'b1;
                    if (step_q == len_q - CNT_W'(1)) begin
                        step_d  = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (step_q == DRAIN_LAST) begin
                    step_d = '0;
                    if (tile_q != tiles_q - CNT_W'(1)) begin
                        tile_d  = tile_q + 1'b1;
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (iAbort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        oBusy       = (state_q != ST_IDLE);
        oDone       = (state_q == ST_DONE);
        oClearAcc   = (state_q == ST_CLEAR);
        oDataRdEn   = (state_q == ST_FEED) && !iStall;
        oWeightRdEn = (state_q == ST_FEED) && !iStall;
    end

    assign oErr                = err_q;
    assign oDataAddr           = dptr_q;
    assign oWeightAddr         = wptr_q;
    assign oCfsInputPattern    = pattern_q;
    assign oCfsPassDataLeft    = pass_q;
    assign oCfsOutputLeftShift = shift_q;
    assign oTileIdx            = tile_q;
    assign oDbgState           = state_q;

endmodule

// File: tb/tb_pe_cube_seq.sv
// Directed bench for pe_cube_seq: a negedge monitor logs every issued read,
// and each job's log is compared with an address list built from the job's settings.
module tb_pe_cube_seq;

    localparam int ARRAY_NUM = 3;
    localparam int ADDR_W    = 10;
    localparam int CNT_W     = 8;
    localparam int DRAIN     = 4;

    localparam logic [8:0] PAT_OK  = 9'b100_010_001;
    localparam logic [8:0] PAT_BAD = 9'b101_000_000;

    logic                   iClk = 1'b0;
    logic                   iRstN;
    logic                   iStart;
    logic                   iAbort;
    logic                   iStall;
    logic [CNT_W-1:0]       iCfgLen;
    logic [CNT_W-1:0]       iCfgTiles;
    logic [ADDR_W-1:0]      iCfgDataBase;
    logic [ADDR_W-1:0]      iCfgWeightBase;
    logic [3*ARRAY_NUM-1:0] iCfgPattern;
    logic [ARRAY_NUM-2:0]   iCfgPassLeft;
    logic [4:0]             iCfgShift;
    logic                   oBusy;
    logic                   oDone;
    logic                   oErr;
    logic                   oDataRdEn;
    logic                   oWeightRdEn;
    logic [ADDR_W-1:0]      oDataAddr;
    logic [ADDR_W-1:0]      oWeightAddr;
    logic                   oClearAcc;
    logic [3*ARRAY_NUM-1:0] oCfsInputPattern;
    logic [ARRAY_NUM-2:0]   oCfsPassDataLeft;
    logic [4:0]             oCfsOutputLeftShift;
    logic [CNT_W-1:0]       oTileIdx;
    logic [2:0]             oDbgState;

    pe_cube_seq #(
        .ARRAY_NUM(ARRAY_NUM), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iAbort(iAbort), .iStall(iStall),
        .iCfgLen(iCfgLen), .iCfgTiles(iCfgTiles), .iCfgDataBase(iCfgDataBase),
        .iCfgWeightBase(iCfgWeightBase), .iCfgPattern(iCfgPattern),
        .iCfgPassLeft(iCfgPassLeft), .iCfgShift(iCfgShift),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
        .oDataRdEn(oDataRdEn), .oWeightRdEn(oWeightRdEn),
        .oDataAddr(oDataAddr), .oWeightAddr(oWeightAddr), .oClearAcc(oClearAcc),
        .oCfsInputPattern(oCfsInputPattern), .oCfsPassDataLeft(oCfsPassDataLeft),
        .oCfsOutputLeftShift(oCfsOutputLeftShift), .oTileIdx(oTileIdx),
        .oDbgState(oDbgState)
    );

    // Clock and cycle counter
    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Monitor: log {tile, data addr, weight addr} per read, count clears/dones
    logic [27:0] got_q[$];
    int clr_cnt  = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int bad_cnt  = 0;

    always @(negedge iClk) begin
        if (oDataRdEn) got_q.push_back({oTileIdx, oDataAddr, oWeightAddr});
        if (oDataRdEn != oWeightRdEn) bad_cnt++;
        if (oClearAcc) begin
            clr_cnt++;
            if (oDataRdEn) bad_cnt++;
        end
        if (oDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cfg(input int len, input int tiles, input int dbase, input int wbase,
                             input logic [8:0] pat);
        iCfgLen        = CNT_W'(len);
        iCfgTiles      = CNT_W'(tiles);
        iCfgDataBase   = ADDR_W'(dbase);
        iCfgWeightBase = ADDR_W'(wbase);
        iCfgPattern    = pat;
        iCfgPassLeft   = 2'b10;
        iCfgShift      = 5'd3;
    endtask

    // Driver + scoreboard for one complete job, with an optional stall window
    task automatic run_job(input string tag, input int len, input int tiles, input int dbase,
                           input int wbase, input int stall_at, input int stall_n);
        logic [27:0]       exp_q[$];
        logic [ADDR_W-1:0] d;
        logic [ADDR_W-1:0] w;
        logic [7:0]        t8;
        int base_rd, base_clr, base_done, k0, budget, stall_left;
        base_rd    = got_q.size();
        base_clr   = clr_cnt;
        base_done  = done_cnt;
        stall_left = stall_n;
        @(posedge iClk); #1;
        drive_cfg(len, tiles, dbase, wbase, PAT_OK);
        iStart = 1'b1;
        k0 = cyc;
        @(posedge iClk); #1;
        iStart = 1'b0;
        check({tag, "_clear_busy"}, 32'({oBusy, oClearAcc, oDataRdEn}), 32'b110);
        budget = 0;
        while (done_cnt == base_done && budget < 500) begin
            iStall = (stall_left > 0) && (got_q.size() - base_rd == stall_at);
            if (iStall) stall_left--;
            @(posedge iClk); #1;
            budget++;
        end
        iStall = 1'b0;
        check({tag, "_timeout"}, 32'(budget < 500), 32'd1);
        check({tag, "_idle_after"}, 32'(oBusy), 32'd0);
        check({tag, "_latency"}, 32'(done_cyc - k0), 32'(tiles * (len + 1 + DRAIN) + 1 + stall_n));
        check({tag, "_clears"}, 32'(clr_cnt - base_clr), 32'(tiles));
        d = ADDR_W'(dbase);
        for (int t = 0; t < tiles; t++) begin
            t8 = 8'(t);
            for (int s = 0; s < len; s++) begin
                w = ADDR_W'(wbase + s);
                exp_q.push_back({t8, d, w});
                d = d + 1'b1;
            end
        end
        check({tag, "_nreads"}, 32'(got_q.size() - base_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base_rd + i < got_q.size(); i++) begin
            check($sformatf("%s_rd%0d", tag, i), 32'(got_q[base_rd + i]), 32'(exp_q[i]));
        end
        check({tag, "_cfs"}, 32'({oCfsInputPattern, oCfsPassDataLeft, oCfsOutputLeftShift}),
              32'({PAT_OK, 2'b10, 5'd3}));
    endtask

    task automatic err_job(input string tag, input int len, input int tiles, input logic [8:0] pat);
        int base_rd;
        base_rd = got_q.size();
        @(posedge iClk); #1;
        drive_cfg(len, tiles, 16, 32, pat);
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        check({tag, "_err_pulse"}, 32'({oErr, oBusy}), 32'b10);
        @(posedge iClk); #1;
        check({tag, "_err_clear"}, 32'({oErr, oBusy}), 32'b00);
        check({tag, "_no_reads"}, 32'(got_q.size() - base_rd), 32'd0);
    endtask

    task automatic abort_job();
        int base_rd, base_done, budget;
        base_rd   = got_q.size();
        base_done = done_cnt;
        @(posedge iClk); #1;
        drive_cfg(4, 1, 'h040, 'h100, PAT_OK);
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        budget = 0;
        while (got_q.size() - base_rd < 2 && budget < 50) begin
            @(posedge iClk); #1;
            budget++;
        end
        check("abort_wait", 32'(budget < 50), 32'd1);
        check("abort_step2_addr", 32'(oDataAddr), 32'h042);
        iAbort = 1'b1;
        @(posedge iClk); #1;
        iAbort = 1'b0;
        check("abort_idle", 32'({oBusy, oDataRdEn, oWeightRdEn, oClearAcc, oDbgState}), 32'd0);
        repeat (12) @(posedge iClk);
        #1;
        check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
        run_job("restart", 4, 1, 'h040, 'h100, 0, 0);
    endtask

    task automatic reset_mid_drain();
        int base_rd, base_done, budget;
        base_rd   = got_q.size();
        base_done = done_cnt;
        @(posedge iClk); #1;
        drive_cfg(2, 1, 'h080, 'h300, PAT_OK);
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        budget = 0;
        while (got_q.size() - base_rd < 2 && budget < 50) begin
            @(posedge iClk); #1;
            budget++;
        end
        @(posedge iClk); #1;
        check("rst_in_drain", 32'(oDbgState), 32'd3);
        #2 iRstN = 1'b0;
        #1;
        check("rst_async_ctrl", 32'({oBusy, oDone, oErr, oDataRdEn, oWeightRdEn, oClearAcc}), 32'd0);
        check("rst_async_addr", 32'({oDataAddr, oWeightAddr}), 32'd0);
        check("rst_async_cfs", 32'({oCfsInputPattern, oCfsPassDataLeft, oCfsOutputLeftShift}), 32'd0);
        check("rst_async_tile", 32'({oTileIdx, oDbgState}), 32'd0);
        @(negedge iClk);
        iRstN = 1'b1;
        repeat (8) @(posedge iClk);
        #1;
        check("rst_stay_idle", 32'({oBusy, done_cnt - base_done}), 32'd0);
    endtask

    initial begin
        iRstN  = 1'b0;
        iStart = 1'b0;
        iAbort = 1'b0;
        iStall = 1'b0;
        drive_cfg(0, 0, 0, 0, 9'd0);
        #12;
        check("reset_ctrl", 32'({oBusy, oDone, oErr, oDataRdEn, oWeightRdEn, oClearAcc}), 32'd0);
        check("reset_addr_tile", 32'({oDataAddr, oWeightAddr, oTileIdx}), 32'd0);
        @(negedge iClk);
        iRstN = 1'b1;

        run_job("basic", 4, 1, 'h010, 'h200, 0, 0);
        run_job("wrap2t", 3, 2, 'h3FE, 'h200, 0, 0);
        run_job("stall", 4, 1, 'h020, 'h200, 2, 2);
        err_job("len0", 0, 1, PAT_OK);
        err_job("tiles0", 2, 0, PAT_OK);
        err_job("pat5", 2, 1, PAT_BAD);
        abort_job();
        reset_mid_drain();
        check("strobe_sanity", 32'(bad_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_cube_seq.md
PE_CUBE_SEQ -- requirements
Module: pe_cube_seq

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ARRAY_NUM, 3, PE arrays per block.
- ADDR_W, 10, buffer address width.
- CNT_W, 8, step/tile counter width.
- DRAIN_CYCLES, 4, cycles waited after the last feed before a tile closes (min 1).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- iClk, in, 1, single clock; all state on rising edge.
- iRstN, in, 1, reset, asynchronous, active-low.
- iStart, in, 1, job request, sampled only in IDLE.
- iAbort, in, 1, terminate job.
- iStall, in, 1, freeze feeding.
- iCfgLen, in, CNT_W, MAC steps per tile.
- iCfgTiles, in, CNT_W, tiles per job.
- iCfgDataBase, in, ADDR_W, data buffer start address.
- iCfgWeightBase, in, ADDR_W, weight buffer start address.
- iCfgPattern, in, 3*ARRAY_NUM, per-array input pattern code.
- iCfgPassLeft, in, ARRAY_NUM-1, pass-data-left mask.
- iCfgShift, in, 5, output left shift.
- oBusy, out, 1, job in progress.
- oDone, out, 1, one-cycle job completion pulse.
- oErr, out, 1, one-cycle rejected-start pulse.
- oDataRdEn / oWeightRdEn, out, 1 each, buffer read strobes.
- oDataAddr / oWeightAddr, out, ADDR_W each, buffer read addresses.
- oClearAcc, out, 1, accumulator clear to the PE cube.
- oCfsInputPattern, oCfsPassDataLeft, oCfsOutputLeftShift, out, 3*ARRAY_NUM / ARRAY_NUM-1 / 5, latched configuration to the PE cube.
- oTileIdx, out, CNT_W, index of the current tile.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-004 In IDLE with iStart=1: if iCfgLen=0, iCfgTiles=0, or any 3-bit pattern field >4, SHALL pulse oErr for the next cycle and stay in IDLE; otherwise SHALL latch all iCfg* inputs, set oTileIdx=0, data pointer=iCfgDataBase, and go to CLEAR.
REQ-005 SHALL ignore iStart outside IDLE; latched configuration SHALL not change while oBusy=1.
REQ-006 oBusy SHALL be 1 in CLEAR, FEED, DRAIN and DONE, and 0 in IDLE.
REQ-007 CLEAR SHALL last exactly 1 cycle with oClearAcc=1 and both read strobes 0, then go to FEED with step counter=0 and weight pointer=latched weight base.
REQ-008 Each FEED cycle with iStall=0 SHALL assert both read strobes on the current pointers and increment the data pointer, weight pointer and step counter.
REQ-009 A FEED cycle with iStall=1 SHALL deassert both strobes and hold all counters and pointers.
REQ-010 The FEED cycle that issues step Len-1 SHALL transition to DRAIN; a tile therefore issues exactly Len reads per buffer.
REQ-011 DRAIN SHALL last DRAIN_CYCLES cycles with strobes 0 and SHALL ignore iStall. After DRAIN: if oTileIdx<Tiles-1, SHALL increment oTileIdx and go to CLEAR; otherwise SHALL go to DONE.
REQ-012 Across tiles, the data pointer SHALL continue incrementing; the weight pointer SHALL restart at the weight base in each tile.
REQ-013 Pointers SHALL wrap modulo 2^ADDR_W without error.
REQ-014 DONE SHALL last 1 cycle with oDone=1, then go to IDLE; a new iStart SHALL be accepted in the following IDLE cycle.
REQ-015 iAbort=1 in any non-IDLE state SHALL force IDLE on the next edge: strobes and oClearAcc 0 from that cycle, oDone not pulsed. iAbort SHALL take priority over iStall and over the state transitions.
REQ-016 oCfs* SHALL reflect the latched values and SHALL hold them after the job ends, until the next accepted start.

Reset
REQ-017 Asserting iRstN=0 SHALL immediately force IDLE and drive all outputs, counters, pointers and latched configuration to 0, including during a job; operation SHALL resume on the first edge after deassertion.

Verification
REQ-018 Len=4, Tiles=1, DataBase=0x010, WeightBase=0x200, DRAIN_CYCLES=4, start -> CLEAR 1 cycle, data addresses 0x010..0x013 with weight addresses 0x200..0x203 on 4 consecutive strobes, 4 idle cycles, oDone pulse; total 10 cycles from start acceptance.
REQ-019 Len=3, Tiles=2, DataBase=0x3FE -> data addresses 0x3FE, 0x3FF, 0x000, then 0x001..0x003; weights 0x200..0x202 twice; oTileIdx reads 0 then 1; two oClearAcc pulses.
REQ-020 Len=4, iStall high for 2 cycles after the second read -> exactly 4 reads per buffer with addresses contiguous, and completion delayed by 2 cycles.
REQ-021 Len=0, or pattern field =5 -> oErr pulse; oBusy stays 0; no strobes.
REQ-022 iAbort during FEED at step 2 -> IDLE next cycle, no oDone; an immediate restart completes normally. iRstN low mid-DRAIN -> all outputs 0 asynchronously.
